// File: rtl/led_fade_sequencer.sv
// RGB LED colour sequencer: debounces the Pano button, steps a colour mode per press and
// fades the three PWM duty values toward the mode's colour one LSB per step.
module led_fade_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned STEP_CYCLES     = 39062
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       button_n_i,
   output logic [7:0] duty_red_o,
   output logic [7:0] duty_green_o,
   output logic [7:0] duty_blue_o,
   output logic [1:0] mode_o,
   output logic       fade_busy_o
);

   localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned StW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [StW-1:0] StMax = StW'(STEP_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StFade} state_e;

   // Input synchroniser and debouncer
   logic           sync1_q, sync2_q;
   logic           btn_s;
   logic           deb_q, deb_d;
   logic [DbW-1:0] db_cnt_q, db_cnt_d;
   logic           press_q;

   assign btn_s = sync2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= button_n_i;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = '0;
      if (btn_s != deb_q) begin
         if (db_cnt_q == DbMax) begin
            deb_d = btn_s;
         end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
         end
      end
   end

   // press_q pulses for one cycle after the debounced level falls; releases are ignored
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         deb_q    <= 1'b1;
         db_cnt_q <= '0;
         press_q  <= 1'b0;
      end else begin
         deb_q    <= deb_d;
         db_cnt_q <= db_cnt_d;
         press_q  <= deb_q & ~deb_d;
      end
   end

   // Fade engine
   state_e         state_q;
   logic [1:0]     mode_q;
   logic [7:0]     red_q, green_q, blue_q;
   logic [StW-1:0] step_cnt_q;
   logic           busy_q;
   logic [7:0]     tgt_r, tgt_g, tgt_b;
   logic           tick;
   logic           at_target;

   always_comb begin
      tgt_r = 8'd0;
      tgt_g = 8'd0;
      tgt_b = 8'd0;
      case (mode_q)
         2'd1: tgt_r = 8'd255;
         2'd2: tgt_g = 8'd255;
         2'd3: begin
            tgt_r = 8'd255;
            tgt_g = 8'd255;
            tgt_b = 8'd255;
         end
         default: ;
      endcase
   end

   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      if (cur < tgt) begin
         return cur + 8'd1;
      end else if (cur > tgt) begin
         return cur - 8'd1;
      end
      return cur;
   endfunction

   assign tick      = (step_cnt_q == StMax);
   assign at_target = (red_q == tgt_r) && (green_q == tgt_g) && (blue_q == tgt_b);

   // A tick coinciding with a press steps toward the old target, since mode_q is still old.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         mode_q     <= 2'd0;
         red_q      <= 8'd0;
         green_q    <= 8'd0;
         blue_q     <= 8'd0;
         step_cnt_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               step_cnt_q <= '0;
               if (press_q) begin
                  mode_q  <= mode_q + 2'd1;
                  state_q <= StFade;
                  busy_q  <= 1'b1;
               end
            end
            StFade: begin
               step_cnt_q <= tick ? '0 : step_cnt_q + StW'(1);
               if (tick) begin
                  red_q   <= step_toward(red_q, tgt_r);
                  green_q <= step_toward(green_q, tgt_g);
                  blue_q  <= step_toward(blue_q, tgt_b);
               end
               if (press_q) begin
                  mode_q <= mode_q + 2'd1;
               end else if (at_target) begin
                  state_q    <= StIdle;
                  busy_q     <= 1'b0;
                  step_cnt_q <= '0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign duty_red_o   = red_q;
   assign duty_green_o = green_q;
   assign duty_blue_o  = blue_q;
   assign mode_o       = mode_q;
   assign fade_busy_o  = busy_q;

endmodule
